// File: rtl/id_stage_pipe_if.sv
// Handshake/bus bundle between IF/ID, the decode stage and EX.
// Optional out_illegal exists only when ID_ILLEGAL_TRAP_EN is defined.
interface id_stage_pipe_if #(
    parameter int XLEN             = 32,
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int INST_BITWIDTH    = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [INST_BITWIDTH-1:0]    in_inst;
    logic [XLEN-1:0]             in_pc;
    logic                        flush;

    logic                        out_valid;
    logic                        out_ready;
    logic [XLEN-1:0]             out_pc;
    logic [REG_NUM_BITWIDTH-1:0] out_rs1;
    logic [REG_NUM_BITWIDTH-1:0] out_rs2;
    logic [REG_NUM_BITWIDTH-1:0] out_rd;
    logic [XLEN-1:0]             out_imm;
    logic [6:0]                  out_opcode;
    logic [3:0]                  out_alu_fn;
    logic                        out_branch;
    logic                        out_jump;
    logic                        out_mem_read;
    logic                        out_mem_to_reg;
    logic                        out_mem_write;
    logic                        out_alu_src;
    logic                        out_reg_write;
    logic [1:0]                  out_alu_op;
    logic                        hazard_stall;
`ifdef ID_ILLEGAL_TRAP_EN
    logic                        out_illegal;
`endif

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_opcode, out_alu_fn, out_branch, out_jump, out_mem_read,
               out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write,
               out_alu_op, hazard_stall
`ifdef ID_ILLEGAL_TRAP_EN
             , out_illegal
`endif
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_opcode, out_alu_fn, out_branch, out_jump, out_mem_read,
               out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write,
               out_alu_op, hazard_stall
`ifdef ID_ILLEGAL_TRAP_EN
             , out_illegal
`endif
    );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I instruction-decode stage: registered bundle with valid/ready, load-use bubble and flush.
// Define ID_ILLEGAL_TRAP_EN to add out_illegal and squash control for illegal encodings.
module id_stage_pipe #(
    parameter int XLEN             = 32,
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int INST_BITWIDTH    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    id_stage_pipe_if.slave     bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0]             pc;
        logic [REG_NUM_BITWIDTH-1:0] rs1;
        logic [REG_NUM_BITWIDTH-1:0] rs2;
        logic [REG_NUM_BITWIDTH-1:0] rd;
        logic [XLEN-1:0]             imm;
        logic [6:0]                  opcode;
        logic [3:0]                  alu_fn;
        logic                        branch;
        logic                        jump;
        logic                        mem_read;
        logic                        mem_to_reg;
        logic                        mem_write;
        logic                        alu_src;
        logic                        reg_write;
        logic [1:0]                  alu_op;
`ifdef ID_ILLEGAL_TRAP_EN
        logic                        illegal;
`endif
    } bundle_t;

    bundle_t     bundle_q, bundle_d;
    bundle_t     dec;
    logic        valid_q, valid_d;
    logic        stall_q, stall_d;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [31:0] imm32;
    logic        rs1_used;
    logic        rs2_used;
    logic        adv;
    logic        hazard;
    logic        accept;

    assign inst   = bus.in_inst[31:0];
    assign opcode = inst[6:0];

    // Combinational decode of the offered instruction; captured only on accept.
    always_comb begin
        dec        = '0;
        imm32      = 32'd0;
        dec.pc     = bus.in_pc;
        dec.rs1    = REG_NUM_BITWIDTH'(inst[19:15]);
        dec.rs2    = REG_NUM_BITWIDTH'(inst[24:20]);
        dec.rd     = REG_NUM_BITWIDTH'(inst[11:7]);
        dec.opcode = opcode;
        dec.alu_fn = {inst[30], inst[14:12]};

        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
            end
            OP_LOAD: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = 2'b00;
                imm32          = {{20{inst[31]}}, inst[31:20]};
            end
            OP_IMM: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b11;
                imm32         = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b00;
                imm32         = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
                imm32      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                imm32         = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_JALR: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm32         = {{20{inst[31]}}, inst[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b00;
                imm32         = {inst[31:12], 12'd0};
            end
            default: begin
            end
        endcase

        // Sign-extending cast keeps XLEN > 32 builds correct without zero-width replications.
        dec.imm = XLEN'($signed(imm32));

`ifdef ID_ILLEGAL_TRAP_EN
        case (opcode)
            OP_R:      dec.illegal = (inst[31:25] != 7'b0000000) && (inst[31:25] != 7'b0100000);
            OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
                       dec.illegal = 1'b0;
            default:   dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.mem_write  = 1'b0;
            dec.alu_src    = 1'b0;
            dec.reg_write  = 1'b0;
            dec.alu_op     = 2'b00;
        end
`endif
    end

    // Source-register usage of the offered instruction, for the load-use check.
    assign rs1_used = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    assign hazard = bus.in_valid && valid_q && bundle_q.mem_read &&
                    (bundle_q.rd != '0) &&
                    ((rs1_used && (dec.rs1 == bundle_q.rd)) ||
                     (rs2_used && (dec.rs2 == bundle_q.rd)));

    assign adv    = !valid_q || bus.out_ready;
    assign accept = bus.in_valid && adv && !hazard;

    // Flush consumes whatever is offered so fetch can move on to the redirect target.
    assign bus.in_ready = bus.flush || (adv && !hazard);

    always_comb begin
        bundle_d = bundle_q;
        valid_d  = valid_q;
        stall_d  = 1'b0;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            bundle_d = dec;
            valid_d  = 1'b1;
        end else if (hazard && bus.out_ready) begin
            valid_d = 1'b0;
            stall_d = 1'b1;
        end else if (adv && !bus.in_valid) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            stall_q  <= stall_d;
            bundle_q <= bundle_d;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.hazard_stall   = stall_q;
    assign bus.out_pc         = bundle_q.pc;
    assign bus.out_rs1        = bundle_q.rs1;
    assign bus.out_rs2        = bundle_q.rs2;
    assign bus.out_rd         = bundle_q.rd;
    assign bus.out_imm        = bundle_q.imm;
    assign bus.out_opcode     = bundle_q.opcode;
    assign bus.out_alu_fn     = bundle_q.alu_fn;
    assign bus.out_branch     = bundle_q.branch;
    assign bus.out_jump       = bundle_q.jump;
    assign bus.out_mem_read   = bundle_q.mem_read;
    assign bus.out_mem_to_reg = bundle_q.mem_to_reg;
    assign bus.out_mem_write  = bundle_q.mem_write;
    assign bus.out_alu_src    = bundle_q.alu_src;
    assign bus.out_reg_write  = bundle_q.reg_write;
    assign bus.out_alu_op     = bundle_q.alu_op;
`ifdef ID_ILLEGAL_TRAP_EN
    assign bus.out_illegal    = bundle_q.illegal;
`endif

endmodule
